// File: rtl/parity_stripe_checker_pkg.sv
// Shared constants and types for the XOR stripe-parity checker.
package parity_stripe_checker_pkg;

    localparam int WIDTH = 4;
    localparam int N     = 8;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_e;

    typedef struct packed {
        logic             ok;
        logic [WIDTH-1:0] syndrome;
        logic [WIDTH-1:0] recovered;
    } stripe_result_t;

endpackage

// File: rtl/parity_accum.sv
// Column-parity XOR accumulator with clear, enable and a per-term mask.
module parity_accum
    import parity_stripe_checker_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         mask,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic [W-1:0] acc_nxt
);

    // acc_nxt lets the owner register a result on the same beat that closes the stripe
    assign acc_nxt = acc ^ (mask ? '0 : din);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/parity_stripe_checker.sv
// Receive-side stripe checker: XORs N data beats plus parity, reports pass/fail
// per stripe and reconstructs a single erased word.
module parity_stripe_checker
    import parity_stripe_checker_pkg::*;
(
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             erase_en,
    input  logic [IDX_W-1:0] erase_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ok,
    output logic [WIDTH-1:0] out_syndrome,
    output logic [WIDTH-1:0] out_recovered,
    output logic [CNT_W-1:0] err_count
);

    state_e           state;
    logic [IDX_W-1:0] cnt;
    logic             erase_q;
    logic [IDX_W-1:0] idx_q;
    stripe_result_t   res;
    stripe_result_t   res_nxt;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] err_q;

    logic             accept;
    logic             first_beat;
    logic             last_beat;
    logic             cur_erase;
    logic [IDX_W-1:0] cur_idx;
    logic             mask;
    logic             clr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    assign accept     = in_valid && in_ready_q;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == IDX_W'(N));

    // Erasure controls ride with beat 0; later beats use the latched copy
    assign cur_erase = first_beat ? (erase_en && (erase_idx <= IDX_W'(N))) : erase_q;
    assign cur_idx   = first_beat ? erase_idx : idx_q;
    assign mask      = cur_erase && (cur_idx == cnt);
    assign clr       = out_valid_q && out_ready;

    parity_accum #(.W(WIDTH)) u_accum (
        .clk     (CLK),
        .rst     (ASYNCRESET),
        .clr     (clr),
        .en      (accept),
        .mask    (mask),
        .din     (in_data),
        .acc     (acc),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        res_nxt           = '0;
        res_nxt.syndrome  = acc_nxt;
        res_nxt.ok        = cur_erase || (acc_nxt == '0);
        res_nxt.recovered = cur_erase ? acc_nxt : '0;
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state       <= ACCUM;
            cnt         <= '0;
            erase_q     <= 1'b0;
            idx_q       <= '0;
            res         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (first_beat) begin
                            erase_q <= cur_erase;
                            idx_q   <= erase_idx;
                        end
                        if (last_beat) begin
                            state       <= REPORT;
                            res         <= res_nxt;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            if (!res_nxt.ok && (err_q != '1))
                                err_q <= err_q + CNT_W'(1);
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state       <= ACCUM;
                        cnt         <= '0;
                        erase_q     <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_ok        = res.ok;
    assign out_syndrome  = res.syndrome;
    assign out_recovered = res.recovered;
    assign err_count     = err_q;

endmodule

// File: tb/tb_parity_stripe_checker.sv
// Bench for parity_stripe_checker: directed table, hand sequences and random stripes.
module tb_parity_stripe_checker;
    import parity_stripe_checker_pkg::*;

    typedef logic [WIDTH-1:0] stripe_t [0:N];

    typedef struct {
        stripe_t          d;
        logic             en;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] syn;
        logic             ok;
        logic [WIDTH-1:0] rec;
        int               hold;
    } vec_t;

    logic             CLK = 1'b0;
    logic             ASYNCRESET = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             erase_en = 1'b0;
    logic [IDX_W-1:0] erase_idx = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_ok;
    logic [WIDTH-1:0] out_syndrome;
    logic [WIDTH-1:0] out_recovered;
    logic [CNT_W-1:0] err_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_err = 0;

    parity_stripe_checker dut (
        .CLK           (CLK),
        .ASYNCRESET    (ASYNCRESET),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .erase_en      (erase_en),
        .erase_idx     (erase_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ok        (out_ok),
        .out_syndrome  (out_syndrome),
        .out_recovered (out_recovered),
        .err_count     (err_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: XOR of every beat that is not the (in-range) erased one
    task automatic ref_stripe(input stripe_t d, input logic en, input int idx,
                              output int syn, output int ok, output int rec);
        bit active;
        active = en && (idx <= N);
        syn = 0;
        for (int k = 0; k <= N; k++)
            if (!(active && k == idx)) syn = syn ^ int'(d[k]);
        ok  = (active || syn == 0) ? 1 : 0;
        rec = active ? syn : 0;
    endtask

    // Entered and left at a falling edge; beats land on the following rising edge
    task automatic send_beats(input stripe_t d, input logic en, input logic [IDX_W-1:0] idx,
                              input int first, input int last, input int gap);
        for (int k = first; k <= last; k++) begin
            int budget;
            if (gap > 0 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                repeat (gap) @(negedge CLK);
            end
            in_valid  = 1'b1;
            in_data   = d[k];
            erase_en  = (k == 0) ? en  : 1'($urandom);
            erase_idx = (k == 0) ? idx : IDX_W'($urandom);
            budget = 50;
            while (!in_ready && budget > 0) begin
                @(negedge CLK);
                budget--;
            end
            if (budget == 0) check("in_ready_timeout", 0, 1);
            @(posedge CLK);
            @(negedge CLK);
        end
        in_valid = 1'b0;
    endtask

    // Called at the first falling edge after the parity beat
    task automatic get_result(input string tag, input int syn, input int ok, input int rec,
                              input int hold);
        if (ok == 0 && exp_err < 255) exp_err++;
        check({tag, ".out_valid"}, int'(out_valid), 1);
        check({tag, ".syndrome"}, int'(out_syndrome), syn);
        check({tag, ".ok"}, int'(out_ok), ok);
        check({tag, ".recovered"}, int'(out_recovered), rec);
        check({tag, ".err_count"}, int'(err_count), exp_err);
        check({tag, ".in_ready_report"}, int'(in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            @(negedge CLK);
            check({tag, ".hold_valid"}, int'(out_valid), 1);
            check({tag, ".hold_syn"}, int'(out_syndrome), syn);
            check({tag, ".hold_ready"}, int'(in_ready), 0);
            check({tag, ".hold_err"}, int'(err_count), exp_err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, int'(out_valid), 0);
        check({tag, ".in_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic run_stripe(input string tag, input stripe_t d, input logic en,
                              input logic [IDX_W-1:0] idx, input int gap, input int hold);
        int syn, ok, rec;
        ref_stripe(d, en, int'(idx), syn, ok, rec);
        send_beats(d, en, idx, 0, N, gap);
        get_result(tag, syn, ok, rec, hold);
    endtask

    initial begin
        vec_t    tbl [6];
        stripe_t base;
        stripe_t d;

        for (int k = 0; k < N; k++) base[k] = WIDTH'(k + 1);
        base[N] = 4'h8;

        tbl[0] = '{d: base, en: 1'b0, idx: 4'd0,  syn: 4'h0, ok: 1'b1, rec: 4'h0, hold: 0};
        tbl[1] = tbl[0]; tbl[1].d[N] = 4'h9; tbl[1].syn = 4'h1; tbl[1].ok = 1'b0;
        tbl[2] = tbl[1];
        tbl[3] = tbl[0]; tbl[3].d[2] = 4'hF; tbl[3].en = 1'b1; tbl[3].idx = 4'd2;
        tbl[3].syn = 4'h3; tbl[3].rec = 4'h3;
        tbl[4] = tbl[0]; tbl[4].d[N] = 4'h5; tbl[4].en = 1'b1; tbl[4].idx = 4'd8;
        tbl[4].syn = 4'h8; tbl[4].rec = 4'h8;
        tbl[5] = tbl[0]; tbl[5].en = 1'b1; tbl[5].idx = 4'd12; tbl[5].hold = 3;

        // Reset state while reset is held
        #12;
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.ok", int'(out_ok), 0);
        check("rst.syndrome", int'(out_syndrome), 0);
        check("rst.recovered", int'(out_recovered), 0);
        check("rst.err_count", int'(err_count), 0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        check("rst.in_ready", int'(in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].ok == 1'b0 && exp_err < 255) exp_err++;
            send_beats(tbl[i].d, tbl[i].en, tbl[i].idx, 0, N, 0);
            check($sformatf("tbl%0d.valid", i), int'(out_valid), 1);
            check($sformatf("tbl%0d.syn", i), int'(out_syndrome), int'(tbl[i].syn));
            check($sformatf("tbl%0d.ok", i), int'(out_ok), int'(tbl[i].ok));
            check($sformatf("tbl%0d.rec", i), int'(out_recovered), int'(tbl[i].rec));
            check($sformatf("tbl%0d.err", i), int'(err_count), exp_err);
            if (tbl[i].ok == 1'b0) exp_err--;
            get_result($sformatf("tbl%0d", i), int'(tbl[i].syn), int'(tbl[i].ok),
                       int'(tbl[i].rec), tbl[i].hold);
        end

        // Randomised stripes with gaps, erasures and report stalls
        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k <= N; k++) d[k] = WIDTH'($urandom);
            run_stripe($sformatf("rnd%0d", s), d, 1'($urandom_range(0, 1)),
                       IDX_W'($urandom_range(0, 15)), $urandom_range(0, 2),
                       $urandom_range(0, 2));
        end

        // Asynchronous reset mid-stripe, away from any clock edge
        base[N] = 4'h9;
        run_stripe("pre_rst", base, 1'b0, 4'd0, 0, 0);
        send_beats(base, 1'b0, 4'd0, 0, 3, 0);
        #2;
        ASYNCRESET = 1'b1;
        #1;
        exp_err = 0;
        check("midrst.err_count", int'(err_count), 0);
        check("midrst.out_valid", int'(out_valid), 0);
        check("midrst.syndrome", int'(out_syndrome), 0);
        check("midrst.in_ready", int'(in_ready), 1);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        base[N] = 4'h8;
        run_stripe("post_rst", base, 1'b0, 4'd0, 0, 0);

        // Saturation of the error counter
        for (int s = 0; s < 257; s++) begin
            int x;
            x = 0;
            for (int k = 0; k < N; k++) begin
                d[k] = WIDTH'($urandom);
                x = x ^ int'(d[k]);
            end
            d[N] = WIDTH'(x ^ $urandom_range(1, 15));
            run_stripe($sformatf("sat%0d", s), d, 1'b0, 4'd0, 0, 0);
        end
        check("sat.final", int'(err_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
